turfbus_tx: RTL and testbench

TURFbus data transmitter. Sits between the LAB4 readout data path and the TURF data lines (`TD_P/N[7:0]`, via the existing OBUFDS bank). It does three things:
- buffers 32-bit event words in a small FIFO,
- arbitrates for the link with a 4-phase request/grant handshake (`SREQ_neg`/`TREQ_neg`),
- serializes each complete packet byte-wise with per-word tags and a trailing XOR checksum.

---
 rtl/turfbus_tx_pkg.sv | 30 +++
 rtl/turfbus_tx_fifo.sv | 44 ++++
 rtl/turfbus_tx.sv | 191 +++++++++++++++++++
 tb/tb_turfbus_tx.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/turfbus_tx_pkg.sv
// TURFbus transmitter shared definitions.
// Byte constants and state encoding, also used by the TURF-side receiver.
package turfbus_tx_pkg;

    localparam logic [7:0] TAG_MORE  = 8'hA5;
    localparam logic [7:0] TAG_LAST  = 8'hAF;
    localparam logic [7:0] IDLE_BYTE = 8'h00;

    typedef enum logic [3:0] {
        ST_IDLE = 4'd0,
        ST_REQ  = 4'd1,
        ST_TAG  = 4'd2,
        ST_B0   = 4'd3,
        ST_B1   = 4'd4,
        ST_B2   = 4'd5,
        ST_B3   = 4'd6,
        ST_CSUM = 4'd7,
        ST_GAP  = 4'd8
    } state_t;

    typedef struct packed {
        logic        last;
        logic [31:0] dat;
    } word_t;

    function automatic logic [7:0] tag_of(input logic last);
        return last ? TAG_LAST : TAG_MORE;
    endfunction

endpackage

// File: rtl/turfbus_tx_fifo.sv
// TURFbus transmitter word FIFO.
// Synchronous, first-word fall-through; writes are dropped when full.
module turfbus_tx_fifo
    import turfbus_tx_pkg::*;
#(
    parameter int AW = 4
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  wr,
    input  logic  rd,
    input  word_t din,
    output word_t dout,
    output logic  full,
    output logic  empty
);

    word_t       mem [2**AW];
    logic [AW:0] wptr;
    logic [AW:0] rptr;

    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW])
                && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign dout  = mem[rptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (wr && !full)
                wptr <= wptr + 1'b1;
            if (rd && !empty)
                rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr && !full)
            mem[wptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/turfbus_tx.sv
// TURFbus data transmitter: FIFO, 4-phase link arbitration,
// tagged byte serializer with trailing XOR checksum.
module turfbus_tx
    import turfbus_tx_pkg::*;
#(
    parameter int FIFO_AW = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] dat_i,
    input  logic        valid_i,
    input  logic        last_i,
    output logic        ready_o,
    output logic [7:0]  td_o,
    output logic        sreq_o,
    input  logic        treq_i,
    output logic        busy_o,
    output logic [15:0] pkts_sent_o
);

    word_t            head;
    word_t            din;
    logic             full;
    logic             empty;
    logic             wr;
    logic             rd;
    logic             treq_m;
    logic             treq_s;
    logic [FIFO_AW:0] pkt_cnt;
    logic             inc;
    logic             dec;

    state_t      state;
    state_t      state_n;
    logic [7:0]  td_q;
    logic [7:0]  td_n;
    logic [7:0]  csum;
    logic [7:0]  csum_n;
    logic [7:0]  tag_byte;
    logic        tag_ok;
    logic        tag_ok_n;
    logic        cur_last;
    logic        last_n;
    logic        sreq_q;
    logic        sreq_n;
    logic        gap_entry;
    logic [15:0] pkts;

    assign din     = '{last: last_i, dat: dat_i};
    assign wr      = valid_i && !full;
    assign ready_o = !full;

    turfbus_tx_fifo #(
        .AW(FIFO_AW)
    ) u_fifo (
        .clk  (clk_i),
        .rst  (rst_i),
        .wr   (wr),
        .rd   (rd),
        .din  (din),
        .dout (head),
        .full (full),
        .empty(empty)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            treq_m <= 1'b0;
            treq_s <= 1'b0;
        end else begin
            treq_m <= treq_i;
            treq_s <= treq_m;
        end
    end

    assign inc = wr && last_i;
    assign dec = rd && head.last;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            pkt_cnt <= '0;
        else if (inc && !dec)
            pkt_cnt <= pkt_cnt + 1'b1;
        else if (dec && !inc)
            pkt_cnt <= pkt_cnt - 1'b1;
    end

    // td_o is loaded with the byte belonging to the state being entered
    assign tag_byte = empty ? IDLE_BYTE : tag_of(head.last);

    always_comb begin
        state_n   = state;
        td_n      = IDLE_BYTE;
        rd        = 1'b0;
        csum_n    = csum;
        tag_ok_n  = tag_ok;
        last_n    = cur_last;
        gap_entry = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (pkt_cnt != '0 || full)
                    state_n = ST_REQ;
            end
            ST_REQ: begin
                if (treq_s) begin
                    state_n  = ST_TAG;
                    td_n     = tag_byte;
                    tag_ok_n = !empty;
                    last_n   = head.last;
                end
            end
            ST_TAG: begin
                if (tag_ok) begin
                    state_n = ST_B0;
                    td_n    = head.dat[7:0];
                    csum_n  = csum ^ td_n;
                end else begin
                    td_n     = tag_byte;
                    tag_ok_n = !empty;
                    last_n   = head.last;
                end
            end
            ST_B0: begin
                state_n = ST_B1;
                td_n    = head.dat[15:8];
                csum_n  = csum ^ td_n;
            end
            ST_B1: begin
                state_n = ST_B2;
                td_n    = head.dat[23:16];
                csum_n  = csum ^ td_n;
            end
            ST_B2: begin
                state_n = ST_B3;
                td_n    = head.dat[31:24];
                csum_n  = csum ^ td_n;
                rd      = 1'b1;
            end
            ST_B3: begin
                if (cur_last) begin
                    state_n = ST_CSUM;
                    td_n    = csum;
                    csum_n  = '0;
                end else begin
                    state_n  = ST_TAG;
                    td_n     = tag_byte;
                    tag_ok_n = !empty;
                    last_n   = head.last;
                end
            end
            ST_CSUM: begin
                state_n   = ST_GAP;
                gap_entry = 1'b1;
            end
            ST_GAP: begin
                if (!treq_s)
                    state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    assign sreq_n = (state_n != ST_IDLE) && (state_n != ST_GAP);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= ST_IDLE;
            td_q     <= IDLE_BYTE;
            csum     <= '0;
            tag_ok   <= 1'b0;
            cur_last <= 1'b0;
            sreq_q   <= 1'b0;
            pkts     <= '0;
        end else begin
            state    <= state_n;
            td_q     <= td_n;
            csum     <= csum_n;
            tag_ok   <= tag_ok_n;
            cur_last <= last_n;
            sreq_q   <= sreq_n;
            if (gap_entry)
                pkts <= pkts + 16'd1;
        end
    end

    assign td_o        = td_q;
    assign sreq_o      = sreq_q;
    assign busy_o      = (state != ST_IDLE);
    assign pkts_sent_o = pkts;

endmodule

// File: tb/tb_turfbus_tx.sv
// Bench for turfbus_tx: receiver-side parser checks every emitted
// byte against a queue of words pushed as they are written.
module tb_turfbus_tx;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic [31:0] dat_i = '0;
    logic        valid_i = 1'b0;
    logic        last_i = 1'b0;
    logic        ready_o;
    logic [7:0]  td_o;
    logic        sreq_o;
    logic        treq_i;
    logic        busy_o;
    logic [15:0] pkts_sent_o;

    // TURF grant model: 0 = withhold, 1 = hold, 2 = follow request
    int mode = 0;
    assign treq_i = (mode == 2) ? sreq_o : (mode == 1);

    always #5 clk = ~clk;

    turfbus_tx #(
        .FIFO_AW(4)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .dat_i      (dat_i),
        .valid_i    (valid_i),
        .last_i     (last_i),
        .ready_o    (ready_o),
        .td_o       (td_o),
        .sreq_o     (sreq_o),
        .treq_i     (treq_i),
        .busy_o     (busy_o),
        .pkts_sent_o(pkts_sent_o)
    );

    typedef struct {
        logic [31:0] d;
        bit          l;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        e;
    int          checks = 0;
    int          errors = 0;
    int          p_st = 0;
    logic [31:0] p_word;
    bit          p_last;
    logic [7:0]  acc = '0;
    logic [7:0]  byte_e;
    logic [7:0]  last_csum = '0;
    int          exp_pkts = 0;
    int          n_more = 0;
    int          n_last = 0;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_i) begin
            p_st = 0;
            acc = '0;
            exp_pkts = 0;
        end else begin
            case (p_st)
                0: begin
                    if (!sreq_o) begin
                        chk("idle_td", td_o, 8'h00);
                    end else if (td_o !== 8'h00) begin
                        chk("tag_expected", exp_q.size() != 0, 1);
                        if (exp_q.size() != 0) begin
                            e = exp_q.pop_front();
                            p_word = e.d;
                            p_last = e.l;
                            chk("tag", td_o, e.l ? 8'hAF : 8'hA5);
                            if (td_o == 8'hA5) n_more++;
                            if (td_o == 8'hAF) n_last++;
                            p_st = 1;
                        end
                    end
                end
                1, 2, 3, 4: begin
                    byte_e = p_word[8*(p_st-1) +: 8];
                    chk("payload", td_o, byte_e);
                    acc = acc ^ byte_e;
                    if (p_st == 4)
                        p_st = p_last ? 5 : 0;
                    else
                        p_st = p_st + 1;
                end
                5: begin
                    chk("csum", td_o, acc);
                    last_csum = td_o;
                    acc = '0;
                    exp_pkts++;
                    p_st = 6;
                end
                default: begin
                    chk("gap", {sreq_o, td_o, pkts_sent_o},
                        {1'b0, 8'h00, 16'(exp_pkts)});
                    p_st = 0;
                end
            endcase
        end
    end

    task automatic wr(input logic [31:0] d, input bit l);
        int n = 0;
        while (!ready_o && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("wr_ready_to", n < 1000, 1);
        valid_i = 1'b1;
        dat_i = d;
        last_i = l;
        exp_q.push_back('{d: d, l: l});
        @(negedge clk);
        valid_i = 1'b0;
        last_i = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!(exp_q.size() == 0 && p_st == 0 && !busy_o) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk(tag, n < 3000, 1);
    endtask

    task automatic wait_td(input string tag, input logic [7:0] v);
        int n = 0;
        while (td_o !== v && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk(tag, n < 500, 1);
    endtask

    initial begin
        #500000;
        $fatal(1, "FAIL watchdog observed=timeout expected=finish");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_td", td_o, 8'h00);
        chk("rst_sreq", sreq_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_pkts", pkts_sent_o, 0);
        chk("rst_ready", ready_o, 1);
        rst_i = 1'b0;
        @(negedge clk);

        // single-word packet with grant held high
        mode = 1;
        wr(32'h12345678, 1'b1);
        wait_td("t1_tag_to", 8'hAF);
        repeat (7) @(negedge clk);
        chk("t1_csum", last_csum, 8'h08);
        chk("t1_pkts", pkts_sent_o, 1);
        chk("t1_gap_sreq", sreq_o, 0);
        chk("t1_gap_busy", busy_o, 1);
        mode = 2;
        wait_done("t1_done");

        // three-word packet
        wr(32'h00000001, 1'b0);
        wr(32'h00000100, 1'b0);
        wr(32'h00010000, 1'b1);
        wait_done("t2_done");
        chk("t2_csum", last_csum, 8'h01);
        chk("t2_pkts", pkts_sent_o, 2);

        // grant withheld, then grant latency
        mode = 0;
        wr(32'hCAFEF00D, 1'b1);
        @(negedge clk);
        repeat (50) begin
            chk("t3_hold", {sreq_o, td_o}, {1'b1, 8'h00});
            @(negedge clk);
        end
        mode = 1;
        @(posedge clk);
        @(posedge clk);
        #1 chk("t3_pre_tag", td_o, 8'h00);
        @(posedge clk);
        #1 chk("t3_tag", td_o, 8'hAF);
        mode = 2;
        wait_done("t3_done");
        chk("t3_pkts", pkts_sent_o, 3);

        // packet longer than the FIFO
        n_more = 0;
        n_last = 0;
        for (int i = 0; i < 40; i++)
            wr({8'(i + 'h31), 8'(i + 'h21), 8'(i + 'h11), 8'(i + 1)},
               i == 39);
        wait_done("t4_done");
        chk("t4_more", n_more, 39);
        chk("t4_last", n_last, 1);
        chk("t4_pkts", pkts_sent_o, 4);

        // next last word accepted on the pop edge of B3
        wr(32'h0BADCAFE, 1'b1);
        wait_td("t5_tag_to", 8'hAF);
        repeat (3) @(negedge clk);
        wr(32'h13572468, 1'b1);
        wait_done("t5_done");
        chk("t5_pkts", pkts_sent_o, 6);
        chk("t5_idle", {busy_o, sreq_o}, 2'b00);

        // asynchronous reset during B2
        wr(32'h11223344, 1'b1);
        wait_td("t6_tag_to", 8'hAF);
        repeat (3) @(negedge clk);
        #2 rst_i = 1'b1;
        #1;
        chk("t6_td", td_o, 8'h00);
        chk("t6_sreq", sreq_o, 0);
        chk("t6_busy", busy_o, 0);
        chk("t6_pkts", pkts_sent_o, 0);
        chk("t6_ready", ready_o, 1);
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst_i = 1'b0;
        repeat (20) @(negedge clk);
        chk("t6_no_residual", {busy_o, sreq_o, td_o}, 10'h000);
        wr(32'h55667788, 1'b0);
        wr(32'h99AABBCC, 1'b1);
        wait_done("t6_done");
        chk("t6_pkts_after", pkts_sent_o, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
